gpu_rect_renderer: RTL

// GPU-side drawing engine that feeds frame_director's gpu_x/gpu_y/gpu_data/gpu_we/gpu_done inputs.
// On each frame start it clears the back buffer to a fill colour, then rasterises a stream of

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/raster_scan.sv | 57 +++++
 rtl/gpu_rect_renderer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the rectangle renderer and its raster scanner.
package gpu_pkg;

  localparam int COORD_W = 10;
  localparam int PIX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAW,
    DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [PIX_W-1:0]   color;
    logic               last;
  } rect_cmd_t;

  // Saturate an inclusive upper bound to the last visible coordinate.
  function automatic logic [COORD_W-1:0] clip_coord(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/raster_scan.sv
// Raster walker: holds the current pixel of an inclusive box and advances x
// then y one position per enabled cycle. The position registers double as the
// renderer's pixel coordinate outputs, so they hold whenever not stepping.
module raster_scan
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x_lo,
  input  logic [COORD_W-1:0] y_lo,
  input  logic [COORD_W-1:0] x_hi,
  input  logic [COORD_W-1:0] y_hi,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_pixel
);

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic [COORD_W-1:0] x_lo_reg;
  logic [COORD_W-1:0] x_hi_reg;
  logic [COORD_W-1:0] y_hi_reg;

  // Load a new box (position starts at its top-left) or step in raster order.
  // The owner never steps on the last pixel, so no coordinate runs past the box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      x_lo_reg <= '0;
      x_hi_reg <= '0;
      y_hi_reg <= '0;
    end else if (load) begin
      x_reg    <= x_lo;
      y_reg    <= y_lo;
      x_lo_reg <= x_lo;
      x_hi_reg <= x_hi;
      y_hi_reg <= y_hi;
    end else if (step) begin
      if (x_reg == x_hi_reg) begin
        x_reg <= x_lo_reg;
        if (y_reg != y_hi_reg) begin
          y_reg <= y_reg + COORD_W'(1);
        end
      end else begin
        x_reg <= x_reg + COORD_W'(1);
      end
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign last_pixel = (x_reg == x_hi_reg) && (y_reg == y_hi_reg);

endmodule

// File: rtl/gpu_rect_renderer.sv
// Frame renderer: on a gpu_start rising edge clears the back buffer, then
// rasterises a stream of clipped filled rectangles one pixel per clock and
// toggles gpu_done once the frame's last command has been drawn.
module gpu_rect_renderer
  import gpu_pkg::*;
#(
  parameter int               WIDTH       = 320,
  parameter int               HEIGHT      = 240,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = 4'h0
) (
  input  logic               gpu_clk_150,
  input  logic               reset_n,
  input  logic               gpu_start,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [PIX_W-1:0]   cmd_color,
  input  logic               cmd_last,
  output logic [COORD_W-1:0] gpu_x,
  output logic [COORD_W-1:0] gpu_y,
  output logic [PIX_W-1:0]   gpu_data,
  output logic               gpu_we,
  output logic               gpu_done,
  output logic               busy
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

  state_t             state_reg;
  state_t             state_next;
  logic               start_q;
  logic               start_armed;
  logic               start_edge;
  logic               we_reg;
  logic               we_next;
  logic [PIX_W-1:0]   data_reg;
  logic [PIX_W-1:0]   data_next;
  logic               done_reg;
  logic               done_next;
  logic               last_reg;
  logic               last_next;
  rect_cmd_t          cmd_clip;
  logic               rect_empty;
  logic               scan_load;
  logic               scan_step;
  logic [COORD_W-1:0] load_x0;
  logic [COORD_W-1:0] load_y0;
  logic [COORD_W-1:0] load_x1;
  logic [COORD_W-1:0] load_y1;
  logic               scan_last;

  // Start edge detector; it only arms after gpu_start has been seen low, so a
  // request already high when reset releases cannot launch a frame.
  always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
    if (!reset_n) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q     <= gpu_start;
      start_armed <= start_armed | ~gpu_start;
    end
  end

  assign start_edge = gpu_start & ~start_q & start_armed;

  // Incoming command with its far corner clipped to the visible area.
  always_comb begin
    cmd_clip.x0    = cmd_x0;
    cmd_clip.y0    = cmd_y0;
    cmd_clip.x1    = clip_coord(cmd_x1, X_MAX);
    cmd_clip.y1    = clip_coord(cmd_y1, Y_MAX);
    cmd_clip.color = cmd_color;
    cmd_clip.last  = cmd_last;
    rect_empty     = (cmd_clip.x0 > cmd_clip.x1) || (cmd_clip.y0 > cmd_clip.y1);
  end

  // State register.
  always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Registered pixel strobe, pixel value, buffer select and latched last flag.
  always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
    if (!reset_n) begin
      we_reg   <= 1'b0;
      data_reg <= '0;
      done_reg <= 1'b0;
      last_reg <= 1'b0;
    end else begin
      we_reg   <= we_next;
      data_reg <= data_next;
      done_reg <= done_next;
      last_reg <= last_next;
    end
  end

  // Next-state and datapath control. The scanner position is the pixel on the
  // bus, so a write is launched by loading/stepping the scanner together with
  // raising the strobe; it is dropped on the cycle after the last pixel.
  always_comb begin
    state_next = state_reg;
    we_next    = 1'b0;
    data_next  = data_reg;
    done_next  = done_reg;
    last_next  = last_reg;
    scan_load  = 1'b0;
    scan_step  = 1'b0;
    load_x0    = '0;
    load_y0    = '0;
    load_x1    = X_MAX;
    load_y1    = Y_MAX;
    cmd_ready  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next = CLEAR;
          scan_load  = 1'b1;
          we_next    = 1'b1;
          data_next  = CLEAR_COLOR;
        end
      end
      CLEAR: begin
        if (scan_last) begin
          state_next = FETCH;
        end else begin
          scan_step = 1'b1;
          we_next   = 1'b1;
        end
      end
      FETCH: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (rect_empty) begin
            state_next = cmd_clip.last ? DONE : FETCH;
          end else begin
            state_next = DRAW;
            scan_load  = 1'b1;
            load_x0    = cmd_clip.x0;
            load_y0    = cmd_clip.y0;
            load_x1    = cmd_clip.x1;
            load_y1    = cmd_clip.y1;
            we_next    = 1'b1;
            data_next  = cmd_clip.color;
            last_next  = cmd_clip.last;
          end
        end
      end
      DRAW: begin
        if (scan_last) begin
          state_next = last_reg ? DONE : FETCH;
        end else begin
          scan_step = 1'b1;
          we_next   = 1'b1;
        end
      end
      DONE: begin
        done_next  = ~done_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  raster_scan u_scan (
    .clk        (gpu_clk_150),
    .rst_n      (reset_n),
    .load       (scan_load),
    .step       (scan_step),
    .x_lo       (load_x0),
    .y_lo       (load_y0),
    .x_hi       (load_x1),
    .y_hi       (load_y1),
    .x          (gpu_x),
    .y          (gpu_y),
    .last_pixel (scan_last)
  );

  assign gpu_we   = we_reg;
  assign gpu_data = data_reg;
  assign gpu_done = done_reg;
  assign busy     = (state_reg != IDLE);

endmodule
